// File: rtl/reg_write_scheduler.sv
// Write-port controller for the 2-read/1-write register file.
// After reset it clears every register once, then grants the single write
// port to requester A (ALU writeback) or B (load writeback) with round-robin
// priority. wrEnable/wrNum/wrData are registered and drive the file directly.
//
// Handshake: a requester raises valid and holds num/data stable; the block
// raises ack combinationally in the same cycle it grants, and the transfer
// happens at the posedge where valid and ack are both high. The granted write
// shows up on the write port in the following cycle.
module reg_write_scheduler #(
    parameter int DATA_WIDTH       = 32,
    parameter int REG_NUM_WIDTH    = 5,
    parameter int REG_FILE_SIZE    = 32,
    parameter int ZERO_REG_DISCARD = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     reqValidA,
    input  logic [REG_NUM_WIDTH-1:0] reqNumA,
    input  logic [DATA_WIDTH-1:0]    reqDataA,
    output logic                     reqAckA,
    input  logic                     reqValidB,
    input  logic [REG_NUM_WIDTH-1:0] reqNumB,
    input  logic [DATA_WIDTH-1:0]    reqDataB,
    output logic                     reqAckB,
    output logic                     wrEnable,
    output logic [REG_NUM_WIDTH-1:0] wrNum,
    output logic [DATA_WIDTH-1:0]    wrData,
    output logic                     initDone
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    localparam logic [REG_NUM_WIDTH-1:0] LAST_IDX = REG_NUM_WIDTH'(REG_FILE_SIZE - 1);

    logic [0:0]               state;
    logic                     ptr;
    logic [REG_NUM_WIDTH-1:0] clear_idx;

    logic                     in_run;
    logic                     grant_any;
    logic [REG_NUM_WIDTH-1:0] grant_num;
    logic [DATA_WIDTH-1:0]    grant_data;
    logic                     grant_writes;

    // Acks only exist in RUN and never while reset is being applied, so a
    // grant cannot be issued in a cycle whose state update is discarded.
    assign in_run  = rst & (state == ST_RUN);
    assign reqAckA = in_run & reqValidA & (~reqValidB | (ptr == PTR_A));
    assign reqAckB = in_run & reqValidB & (~reqValidA | (ptr == PTR_B));

    // Select the winning request's payload and decide whether it really writes.
    always_comb begin
        grant_any    = reqAckA | reqAckB;
        grant_num    = reqAckA ? reqNumA  : reqNumB;
        grant_data   = reqAckA ? reqDataA : reqDataB;
        grant_writes = 1'b1;
        if ((ZERO_REG_DISCARD != 0) && (grant_num == '0)) begin
            grant_writes = 1'b0;
        end
    end

    // Sweep/arbitration state machine and the registered write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_INIT;
            clear_idx <= '0;
            ptr       <= PTR_A;
            wrEnable  <= 1'b0;
            wrNum     <= '0;
            wrData    <= '0;
            initDone  <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    // Register 0 is cleared too; the discard applies to requests only.
                    wrEnable <= 1'b1;
                    wrNum    <= clear_idx;
                    wrData   <= '0;
                    if (clear_idx == LAST_IDX) begin
                        state    <= ST_RUN;
                        initDone <= 1'b1;
                    end else begin
                        clear_idx <= clear_idx + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (grant_any) begin
                        wrEnable <= grant_writes;
                        wrNum    <= grant_num;
                        wrData   <= grant_data;
                        ptr      <= reqAckA ? PTR_B : PTR_A;
                    end else begin
                        // Idle port: keep num/data so the bus does not toggle.
                        wrEnable <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

endmodule
